// File: rtl/cfi_shadow_stack_backend.sv
// CFI checking backend: pops control-flow log entries, keeps a shadow stack of
// return addresses and flags returns whose target does not match the stack top.
package cfi_shadow_stack_backend_pkg;
    localparam int unsigned VLEN = 64;

    typedef enum logic [1:0] {
        CFI_BRANCH = 2'd0,
        CFI_JUMP   = 2'd1,
        CFI_CALL   = 2'd2,
        CFI_RETURN = 2'd3
    } cf_type_e;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        cf_type_e        cf_type;
        logic            is_compressed;
    } cfi_log_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;
endpackage

module cfi_shadow_stack_backend
    import cfi_shadow_stack_backend_pkg::*;
#(
    parameter int unsigned SS_DEPTH         = 16,
    parameter bit          STRICT_UNDERFLOW = 1'b1,
    parameter logic [63:0] FAULT_CAUSE      = 64'd18,
    parameter logic [63:0] FAULT_TVAL       = 64'd3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  cfi_log_t                   log_i,
    input  logic                       queue_empty_i,
    output logic                       queue_pop_o,
    input  logic                       flush_i,
    output exception_t                 cfi_fault_o,
    output logic [$clog2(SS_DEPTH):0]  ss_depth_o
);
    localparam int unsigned PTR_W = $clog2(SS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    cfi_log_t         r_entry;
    logic [VLEN-1:0]  r_stack [SS_DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [CNT_W-1:0] r_cnt;
    exception_t       r_fault;

    logic             w_do_check;
    logic             w_push;
    logic             w_ret;
    logic             w_empty;
    logic             w_full;
    logic             w_fault;
    logic [PTR_W-1:0] w_top_idx;
    logic [VLEN-1:0]  w_top;
    logic [VLEN-1:0]  w_ret_addr;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and pop; a flush abandons CHECK and blocks a new pop
    always_comb begin
        w_state_nxt = r_state;
        queue_pop_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!queue_empty_i) begin
                    queue_pop_o = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            queue_pop_o = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_entry <= '0;
        end else if (queue_pop_o) begin
            r_entry <= log_i;
        end
    end

    always_comb begin
        w_do_check = (r_state == S_CHECK) && !flush_i;
        w_push     = w_do_check && (r_entry.cf_type == CFI_CALL);
        w_ret      = w_do_check && (r_entry.cf_type == CFI_RETURN);
        w_empty    = (r_cnt == '0);
        w_full     = (r_cnt == CNT_W'(SS_DEPTH));
        w_top_idx  = r_tos - PTR_W'(1);
        w_top      = r_stack[w_top_idx];
        w_ret_addr = r_entry.pc + (r_entry.is_compressed ? VLEN'(2) : VLEN'(4));
        w_fault    = w_ret && (w_empty ? STRICT_UNDERFLOW : (w_top != r_entry.target));
    end

    // Stack contents carry no reset; only the pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_stack[r_tos] <= w_ret_addr;
        end
    end

    // Pointers: full stack overwrites the oldest slot, count saturates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tos <= '0;
            r_cnt <= '0;
        end else if (flush_i) begin
            r_tos <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_tos <= r_tos + PTR_W'(1);
            r_cnt <= w_full ? r_cnt : r_cnt + CNT_W'(1);
        end else if (w_ret && !w_empty) begin
            r_tos <= w_top_idx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fault <= '0;
        end else begin
            r_fault <= '0;
            if (w_fault) begin
                r_fault.valid <= 1'b1;
                r_fault.cause <= FAULT_CAUSE;
                r_fault.tval  <= FAULT_TVAL;
            end
        end
    end

    assign cfi_fault_o = r_fault;
    assign ss_depth_o  = r_cnt;

endmodule

// File: tb/tb_cfi_shadow_stack_backend.sv
// Scoreboard bench: a fall-through queue model feeds two DUTs (strict and lax
// underflow); a reference shadow stack predicts fault and depth per entry.
module tb_cfi_shadow_stack_backend;
    import cfi_shadow_stack_backend_pkg::*;

    typedef struct {
        cfi_log_t log;
        bit       flush;
    } stim_t;

    typedef struct {
        exception_t  flt_s;
        exception_t  flt_l;
        int unsigned depth;
    } exp_t;

    localparam exception_t FLT = exception_t'{cause: 64'd18, tval: 64'd3, valid: 1'b1};

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    cfi_log_t   log_i = '0;
    logic       queue_empty_i = 1'b1;
    logic       flush_i = 1'b0;
    logic       pop_s, pop_l;
    exception_t flt_s, flt_l;
    logic [4:0] depth_s, depth_l;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    stim_t           tb_q[$];
    exp_t            sb_q[$];
    logic [63:0]     m_stk[$];
    int unsigned     pop_cyc[$];
    int unsigned     cyc = 0;
    bit              p1 = 0, p2 = 0;

    cfi_shadow_stack_backend #(.SS_DEPTH(16), .STRICT_UNDERFLOW(1'b1)) u_dut_s (
        .clk_i(clk_i), .rst_ni(rst_ni), .log_i(log_i), .queue_empty_i(queue_empty_i),
        .queue_pop_o(pop_s), .flush_i(flush_i), .cfi_fault_o(flt_s), .ss_depth_o(depth_s)
    );

    cfi_shadow_stack_backend #(.SS_DEPTH(16), .STRICT_UNDERFLOW(1'b0)) u_dut_l (
        .clk_i(clk_i), .rst_ni(rst_ni), .log_i(log_i), .queue_empty_i(queue_empty_i),
        .queue_pop_o(pop_l), .flush_i(flush_i), .cfi_fault_o(flt_l), .ss_depth_o(depth_l)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Queue a log entry and predict its outcome with a bounded reference stack
    task automatic enq(input cf_type_e t, input logic [63:0] pc, input logic [63:0] tgt,
                       input bit comp, input bit fl);
        stim_t       s;
        exp_t        e;
        logic [63:0] top;
        s.log   = cfi_log_t'{pc: pc, target: tgt, cf_type: t, is_compressed: comp};
        s.flush = fl;
        tb_q.push_back(s);
        e.flt_s = '0;
        e.flt_l = '0;
        if (fl) begin
            m_stk.delete();
        end else if (t == CFI_CALL) begin
            m_stk.push_back(pc + (comp ? 64'd2 : 64'd4));
            if (m_stk.size() > 16) void'(m_stk.pop_front());
        end else if (t == CFI_RETURN) begin
            if (m_stk.size() > 0) begin
                top = m_stk.pop_back();
                if (top != tgt) begin
                    e.flt_s = FLT;
                    e.flt_l = FLT;
                end
            end else begin
                e.flt_s = FLT;
            end
        end
        e.depth = m_stk.size();
        sb_q.push_back(e);
    endtask

    // Monitor/driver on the falling edge: results, queue head, flush, pop sampling
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            p1 = 0;
            p2 = 0;
        end else begin
            bit   res, in_chk;
            exp_t e;
            stim_t s;
            cyc++;
            res    = p2;
            in_chk = p1;
            if (res) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underrun", 256'(1), 256'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("fault_strict", 256'(flt_s), 256'(e.flt_s));
                    chk("fault_lax", 256'(flt_l), 256'(e.flt_l));
                    chk("depth_strict", 256'(depth_s), 256'(e.depth));
                    chk("depth_lax", 256'(depth_l), 256'(e.depth));
                end
            end else begin
                chk("fault_idle", 256'(flt_s), 256'(0));
                chk("fault_idle_lax", 256'(flt_l), 256'(0));
            end
            flush_i = 1'b0;
            if (in_chk && tb_q.size() != 0) begin
                s = tb_q.pop_front();
                flush_i = s.flush;
            end
            queue_empty_i = (tb_q.size() == 0);
            log_i = (tb_q.size() != 0) ? tb_q[0].log : '0;
            #1;
            if (in_chk) chk("pop_in_check", 256'(pop_s), 256'(0));
            chk("pop_match", 256'(pop_l), 256'(pop_s));
            if (pop_s) pop_cyc.push_back(cyc);
            p2 = in_chk;
            p1 = pop_s;
        end
    end

    // Wait for every queued entry to produce its result, then check pop cadence
    task automatic drain(input int unsigned n);
        int unsigned t = 0;
        while ((tb_q.size() != 0 || sb_q.size() != 0 || p1 || p2) && t < 5000) begin
            @(posedge clk_i);
            t++;
        end
        #1;
        if (t >= 5000) chk("drain_timeout", 256'(1), 256'(0));
        chk("pop_count", 256'(pop_cyc.size()), 256'(n));
        if (pop_cyc.size() == n && n > 0)
            chk("pop_span", 256'(pop_cyc[n-1] - pop_cyc[0]), 256'(2 * (n - 1)));
        pop_cyc.delete();
    endtask

    task automatic start_block();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_pop", 256'(pop_s), 256'(0));
        chk("rst_fault", 256'(flt_s), 256'(0));
        chk("rst_depth", 256'(depth_s), 256'(0));
        @(posedge clk_i);
        #1 rst_ni = 1'b1;

        start_block();
        enq(CFI_CALL, 64'h8000_0100, 64'h0, 1'b0, 1'b0);
        enq(CFI_RETURN, 64'h0, 64'h8000_0104, 1'b0, 1'b0);
        drain(2);

        start_block();
        enq(CFI_CALL, 64'h8000_0200, 64'h0, 1'b1, 1'b0);
        enq(CFI_RETURN, 64'h0, 64'h8000_0208, 1'b0, 1'b0);
        drain(2);

        start_block();
        enq(CFI_RETURN, 64'h0, 64'h1234, 1'b0, 1'b0);
        drain(1);

        start_block();
        for (int i = 0; i <= 16; i++)
            enq(CFI_CALL, 64'h8000_0000 + 64'(i) * 64'h10, 64'h0, 1'b0, 1'b0);
        for (int i = 16; i >= 1; i--)
            enq(CFI_RETURN, 64'h0, 64'h8000_0004 + 64'(i) * 64'h10, 1'b0, 1'b0);
        enq(CFI_RETURN, 64'h0, 64'h8000_0004, 1'b0, 1'b0);
        drain(34);

        start_block();
        for (int i = 1; i <= 3; i++)
            enq(CFI_CALL, 64'h8000_1000 * 64'(i), 64'h0, 1'b0, 1'b0);
        enq(CFI_RETURN, 64'h0, 64'hdead_0000, 1'b0, 1'b1);
        enq(CFI_RETURN, 64'h0, 64'h8000_3004, 1'b0, 1'b0);
        drain(5);

        start_block();
        for (int k = 0; k < 2; k++) begin
            enq(CFI_BRANCH, 64'h100, 64'h200, 1'b0, 1'b0);
            enq(CFI_JUMP, 64'h300, 64'h400, 1'b1, 1'b0);
            enq(CFI_CALL, 64'h8000_0300 + 64'(k) * 64'h100, 64'h0, k[0], 1'b0);
            enq(CFI_RETURN, 64'h0, 64'h8000_0304 + 64'(k) * 64'hfe, 1'b0, 1'b0);
        end
        drain(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
